// File: rtl/rank_sort_stream.sv
// Streaming stable rank-count sorter: loads N words, ranks them one element per
// cycle, then emits them in order. Define SORT_INDEX_EN to add out_index.
module rank_sort_stream #(
  parameter int N     = 6,
  parameter int WIDTH = 8,
  localparam int IW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             descending,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
`ifdef SORT_INDEX_EN
  output logic [IW-1:0]    out_index,
`endif
  output logic             busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_LOAD, S_RANK, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_q, wr_d, rd_q, rd_d, i_q, i_d;
  logic            dir_q, dir_d;
  logic            up_q;
  logic [WIDTH-1:0] ibuf_q [N];
  logic [WIDTH-1:0] obuf_q [N];
`ifdef SORT_INDEX_EN
  logic [IW-1:0]   oidx_q [N];
`endif
  logic            in_fire, out_fire;
  logic [IW-1:0]   i_idx, rd_idx, wr_idx, rank_w;

  function automatic logic precedes(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             dir);
    return dir ? (a > b) : (a < b);
  endfunction

  assign i_idx  = i_q[IW-1:0];
  assign rd_idx = rd_q[IW-1:0];
  assign wr_idx = wr_q[IW-1:0];

  // up_q keeps in_ready low until the first edge after reset release
  assign in_ready  = (state_q == S_LOAD) && up_q;
  assign out_valid = (state_q == S_EMIT);
  assign in_fire   = in_valid && in_ready && !clear;
  assign out_fire  = out_valid && out_ready && !clear;
  assign out_data  = out_valid ? obuf_q[rd_idx] : '0;
  assign out_last  = out_valid && (rd_q == CW'(N - 1));
  assign busy      = (state_q != S_LOAD) || (wr_q != '0);
`ifdef SORT_INDEX_EN
  assign out_index = out_valid ? oidx_q[rd_idx] : '0;
`endif

  // Ties count as preceding only for lower input positions, which makes the sort stable
  always_comb begin
    rank_w = '0;
    for (int j = 0; j < N; j++) begin
      if ((IW'(j) != i_idx) &&
          (precedes(ibuf_q[j], ibuf_q[i_idx], dir_q) ||
           ((ibuf_q[j] == ibuf_q[i_idx]) && (IW'(j) < i_idx))))
        rank_w = rank_w + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    i_d     = i_q;
    dir_d   = dir_q;
    if (clear) begin
      state_d = S_LOAD;
      wr_d    = '0;
      rd_d    = '0;
      i_d     = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (in_fire) begin
            if (wr_q == '0) dir_d = descending;
            if (wr_q == CW'(N - 1)) begin
              wr_d    = '0;
              state_d = S_RANK;
            end else begin
              wr_d = wr_q + CW'(1);
            end
          end
        end
        S_RANK: begin
          if (i_q == CW'(N - 1)) begin
            i_d     = '0;
            state_d = S_EMIT;
          end else begin
            i_d = i_q + CW'(1);
          end
        end
        S_EMIT: begin
          if (out_fire) begin
            if (rd_q == CW'(N - 1)) begin
              rd_d    = '0;
              state_d = S_LOAD;
            end else begin
              rd_d = rd_q + CW'(1);
            end
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      wr_q    <= '0;
      rd_q    <= '0;
      i_q     <= '0;
      dir_q   <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      i_q     <= i_d;
      dir_q   <= dir_d;
      up_q    <= 1'b1;
    end
  end

  // Storage carries no reset; reads are gated by the control state
  always_ff @(posedge clk) begin
    if (in_fire) ibuf_q[wr_idx] <= in_data;
    if ((state_q == S_RANK) && !clear) begin
      obuf_q[rank_w] <= ibuf_q[i_idx];
`ifdef SORT_INDEX_EN
      oidx_q[rank_w] <= i_idx;
`endif
    end
  end

endmodule

// File: tb/tb_rank_sort_stream.sv
// Bench for rank_sort_stream (N=6, WIDTH=8): selection-sort reference model,
// per-cycle output checks, and literal frames from the test plan.
module tb_rank_sort_stream;

  localparam int N = 6;

  logic       clk, rst, clear, descending, in_valid, in_ready;
  logic [7:0] in_data, out_data;
  logic       out_valid, out_ready, out_last, busy;
`ifdef SORT_INDEX_EN
  logic [2:0] out_index;
`endif

  rank_sort_stream #(.N(N), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .descending(descending),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
`ifdef SORT_INDEX_EN
    .out_index(out_index),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cur_d[$];
  bit cur_dir;
  int exp_d[$], exp_i[$];
  int seen_d[$], seen_i[$];
  int rank_cnt = 0;
  bit stall_prev = 0;
  int prev_d, prev_l;
  int bp = 0, ph = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic void flush();
    cur_d.delete(); exp_d.delete(); exp_i.delete(); rank_cnt = 0;
  endfunction

  // Stable ordering: repeatedly take the best remaining key, lowest position on ties
  function automatic void build();
    bit used[N];
    int b;
    for (int j = 0; j < N; j++) used[j] = 0;
    for (int k = 0; k < N; k++) begin
      b = -1;
      for (int j = 0; j < N; j++)
        if (!used[j] && (b < 0 || (cur_dir ? cur_d[j] > cur_d[b] : cur_d[j] < cur_d[b])))
          b = j;
      used[b] = 1;
      exp_d.push_back(cur_d[b]);
      exp_i.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      flush();
      stall_prev = 0;
    end else begin
      chk("busy", busy, (cur_d.size() > 0 || exp_d.size() > 0));
      chk("out_valid", out_valid, (exp_d.size() > 0 && rank_cnt == 0));
      if (out_valid) chk("in_ready_emit", in_ready, 0);
      if (stall_prev && out_valid) begin
        chk("hold_data", out_data, prev_d);
        chk("hold_last", out_last, prev_l);
      end
      if (rank_cnt > 0) rank_cnt--;
      stall_prev = out_valid && !out_ready && !clear;
      prev_d = out_data;
      prev_l = out_last;
      if (clear) begin
        flush();
      end else begin
        if (out_valid && out_ready && exp_d.size() > 0) begin
          chk("out_data", out_data, exp_d[0]);
          chk("out_last", out_last, exp_d.size() == 1);
`ifdef SORT_INDEX_EN
          chk("out_index", out_index, exp_i[0]);
          seen_i.push_back(out_index);
`endif
          seen_d.push_back(out_data);
          void'(exp_d.pop_front());
          void'(exp_i.pop_front());
        end
        if (in_valid && in_ready) begin
          if (cur_d.size() == 0) cur_dir = descending;
          cur_d.push_back(in_data);
          if (cur_d.size() == N) begin
            build();
            rank_cnt = N;
            cur_d.delete();
          end
        end
      end
    end
  end

  // out_ready patterns: 0 always, 1 = 1,0,0 repeating, 2 random, 3 held low
  initial forever begin
    @(posedge clk); #1;
    case (bp)
      0: out_ready = 1'b1;
      1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send_word(input logic [7:0] d, input bit dsc);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; descending = dsc;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready && !rst) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    else begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] v[N], input bit dsc, input bit jitter);
    for (int k = 0; k < N; k++) begin
      if (jitter && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send_word(v[k], (k == 0) ? dsc : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (exp_d.size() == 0 && !out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    else begin @(posedge clk); #1; end
  endtask

  task automatic chk_seen(input string nm, input int off, input int e[N]);
    chk({nm, "_count"}, (seen_d.size() >= off + N), 1);
    if (seen_d.size() >= off + N)
      for (int k = 0; k < N; k++) chk(nm, seen_d[off + k], e[k]);
  endtask

  logic [7:0] fr[N];
  int lat;

  initial begin
    rst = 1'b0; clear = 1'b0; descending = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
`ifdef SORT_INDEX_EN
    chk("rst_out_index", out_index, 0);
`endif
    rst = 1'b0;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", in_ready, 1);

    // ascending with latency measurement
    seen_d.delete(); seen_i.delete();
    fr = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
    send_frame(fr, 1'b0, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, N + 1);
    @(posedge clk); #1;
    drain();
    chk_seen("asc", 0, '{1, 2, 3, 5, 7, 9});

    // descending
    seen_d.delete(); seen_i.delete();
    send_frame(fr, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_seen("desc", 0, '{9, 7, 5, 3, 2, 1});

    // stability with duplicate keys
    seen_d.delete(); seen_i.delete();
    fr = '{8'd4, 8'd4, 8'd0, 8'd4, 8'd0, 8'd255};
    send_frame(fr, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_seen("stable", 0, '{0, 0, 4, 4, 4, 255});
`ifdef SORT_INDEX_EN
    if (seen_i.size() >= N) begin
      int ei[N] = '{2, 4, 0, 1, 3, 5};
      for (int k = 0; k < N; k++) chk("stable_index", seen_i[k], ei[k]);
    end
`endif

    // backpressure 1,0,0
    seen_d.delete(); seen_i.delete();
    bp = 1; ph = 0;
    fr = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
    send_frame(fr, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_seen("bp", 0, '{1, 2, 3, 5, 7, 9});
    bp = 0;

    // clear after three words, discarding a coincident word
    seen_d.delete(); seen_i.delete();
    send_word(8'd50, 1'b1); send_word(8'd40, 1'b0); send_word(8'd30, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_busy", busy, 0);
    fr = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_frame(fr, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_seen("clear", 0, '{1, 2, 3, 4, 5, 6});

    // async reset during a stalled EMIT
    bp = 3;
    fr = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    send_frame(fr, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("pre_rst_out_valid", out_valid, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_emit_out_valid", out_valid, 0);
    chk("rst_emit_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bp = 0;
    seen_d.delete(); seen_i.delete();
    fr = '{8'd7, 8'd0, 8'd200, 8'd7, 8'd3, 8'd1};
    send_frame(fr, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_seen("after_rst", 0, '{200, 7, 7, 3, 1, 0});

    // back-to-back frames, in_valid held high, direction per frame
    seen_d.delete(); seen_i.delete();
    fr = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
    send_frame(fr, 1'b0, 1'b0);
    send_frame(fr, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();
    chk_seen("b2b_asc", 0, '{1, 2, 3, 5, 7, 9});
    chk_seen("b2b_desc", N, '{9, 7, 5, 3, 2, 1});

    // randomized frames against the model
    bp = 2;
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < N; k++)
        fr[k] = (f % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      send_frame(fr, 1'($urandom_range(0, 1)), 1'b1);
    end
    in_valid = 1'b0;
    drain();
    bp = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
